// File: rtl/io_bus_master.sv
// IO bus master: bridges single CPU IO requests onto the peripheral register bus and
// presents external interrupt-controller requests to the CPU, one per request level.
module io_bus_master #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        Sys_Clock,
  input  logic        Sys_Reset,
  input  logic        Req_Valid,
  input  logic        Req_Write,
  input  logic [29:0] Req_Address,
  input  logic [31:0] Req_WrData,
  output logic        Req_Ready,
  output logic        Resp_Valid,
  output logic [31:0] Resp_RdData,
  output logic [29:0] Sys_Address,
  output logic [31:0] Sys_WrData,
  output logic        Sys_WrEn,
  output logic        Sys_RdEn,
  input  logic [31:0] Sys_RdData,
  input  logic        EIC_IntReq,
  input  logic        EIC_IntId,
  output logic        EIC_IntAck,
  input  logic        Int_Enable,
  input  logic        Int_Take,
  output logic        Int_Pending,
  output logic        Int_Id
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StWait,
    StResp,
    StInt
  } stateT;

  localparam logic [3:0] CntLoad = 4'(RD_LATENCY);

  stateT       stateQ, stateD;
  logic [3:0]  cntQ, cntD;
  logic        armedQ;
  logic        armedD;
  logic        intAckQ;
  logic        intIdQ;
  logic [29:0] addrQ;
  logic [31:0] wrDataQ;
  logic [31:0] rdDataQ;
  logic        intGo;
  logic        accept;
  logic        capture;
  logic        takeInt;

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    intGo   = (stateQ == StIdle) && EIC_IntReq && Int_Enable && armedQ;
    accept  = (stateQ == StIdle) && !intGo && Req_Valid;
    capture = (stateQ == StWait) && (cntQ == 4'd1);
    takeInt = (stateQ == StInt) && Int_Take;
    // A low request level re-arms; set wins over a same-cycle take so no edge is missed.
    armedD  = !EIC_IntReq || (armedQ && !takeInt);
    case (stateQ)
      StIdle: begin
        if (intGo) begin
          stateD = StInt;
        end else if (Req_Valid) begin
          stateD = Req_Write ? StWrite : StRead;
        end
      end
      StWrite: stateD = StIdle;
      StRead: begin
        stateD = StWait;
        cntD   = CntLoad;
      end
      StWait: begin
        cntD = cntQ - 4'd1;
        if (cntQ == 4'd1) begin
          stateD = StResp;
        end
      end
      StResp: stateD = StIdle;
      StInt: begin
        if (Int_Take) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      stateQ  <= StIdle;
      cntQ    <= 4'd0;
      armedQ  <= 1'b1;
      intAckQ <= 1'b0;
      intIdQ  <= 1'b0;
      addrQ   <= 30'd0;
      wrDataQ <= 32'd0;
      rdDataQ <= 32'd0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      armedQ  <= armedD;
      intAckQ <= takeInt;
      if (intGo) begin
        intIdQ <= EIC_IntId;
      end
      if (accept) begin
        addrQ   <= Req_Address;
        wrDataQ <= Req_WrData;
      end
      if (capture) begin
        rdDataQ <= Sys_RdData;
      end
    end
  end

  // Strobes decode straight from state so a reset kills them in the same cycle.
  assign Req_Ready   = (stateQ == StIdle) && !intGo;
  assign Resp_Valid  = (stateQ == StWrite) || (stateQ == StResp);
  assign Sys_WrEn    = (stateQ == StWrite);
  assign Sys_RdEn    = (stateQ == StRead);
  assign Int_Pending = (stateQ == StInt);
  assign Int_Id      = intIdQ;
  assign EIC_IntAck  = intAckQ;
  assign Sys_Address = addrQ;
  assign Sys_WrData  = wrDataQ;
  assign Resp_RdData = rdDataQ;

endmodule

// File: tb/tb_io_bus_master.sv
// Scoreboard bench for io_bus_master: expected responses are queued at accept time and
// checked when Resp_Valid appears; a small peripheral model returns read data on time.
module tb_io_bus_master;

  localparam int unsigned RdLat = 3;

  logic        Sys_Clock = 1'b0;
  logic        Sys_Reset;
  logic        Req_Valid, Req_Write;
  logic [29:0] Req_Address;
  logic [31:0] Req_WrData;
  logic        Req_Ready, Resp_Valid;
  logic [31:0] Resp_RdData;
  logic [29:0] Sys_Address;
  logic [31:0] Sys_WrData;
  logic        Sys_WrEn, Sys_RdEn;
  logic [31:0] Sys_RdData;
  logic        EIC_IntReq, EIC_IntId, EIC_IntAck;
  logic        Int_Enable, Int_Take, Int_Pending, Int_Id;

  io_bus_master #(.RD_LATENCY(RdLat)) dut (
    .Sys_Clock  (Sys_Clock),
    .Sys_Reset  (Sys_Reset),
    .Req_Valid  (Req_Valid),
    .Req_Write  (Req_Write),
    .Req_Address(Req_Address),
    .Req_WrData (Req_WrData),
    .Req_Ready  (Req_Ready),
    .Resp_Valid (Resp_Valid),
    .Resp_RdData(Resp_RdData),
    .Sys_Address(Sys_Address),
    .Sys_WrData (Sys_WrData),
    .Sys_WrEn   (Sys_WrEn),
    .Sys_RdEn   (Sys_RdEn),
    .Sys_RdData (Sys_RdData),
    .EIC_IntReq (EIC_IntReq),
    .EIC_IntId  (EIC_IntId),
    .EIC_IntAck (EIC_IntAck),
    .Int_Enable (Int_Enable),
    .Int_Take   (Int_Take),
    .Int_Pending(Int_Pending),
    .Int_Id     (Int_Id)
  );

  typedef struct {
    bit          isWrite;
    logic [29:0] addr;
    logic [31:0] data;
    int          dueCyc;
  } expT;

  expT         expQ[$];
  expT         monE;
  int          cyc = 0;
  int          nChecks = 0;
  int          nFails = 0;
  logic [31:0] lastRd = 32'd0;
  int          rdEnCyc = -100;
  int          rdEnCount = 0;
  logic [29:0] rdAddr = 30'd0;

  always #5 Sys_Clock = ~Sys_Clock;
  always @(posedge Sys_Clock) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] periphData(input logic [29:0] a);
    return 32'h1234_5678 ^ {2'b00, a};
  endfunction

  // Peripheral: data is valid only in the cycle RdLat after the Sys_RdEn cycle.
  always @(negedge Sys_Clock) begin
    if (Sys_RdEn) begin
      rdEnCyc = cyc;
      rdAddr  = Sys_Address;
      rdEnCount++;
    end
    Sys_RdData = (cyc == rdEnCyc + int'(RdLat)) ? periphData(rdAddr) : 32'hDEAD_BEEF;
  end

  always @(negedge Sys_Clock) begin
    if (!Sys_Reset) begin
      checkVal("en_excl", 32'(Sys_WrEn & Sys_RdEn), 32'd0);
      if (Resp_Valid) begin
        if (expQ.size() == 0) begin
          checkVal("unexpected_resp", 32'(Resp_Valid), 32'd0);
        end else begin
          monE = expQ.pop_front();
          checkVal("resp_cycle", 32'(cyc), 32'(monE.dueCyc));
          checkVal("resp_addr", 32'(Sys_Address), 32'(monE.addr));
          if (monE.isWrite) begin
            checkVal("wr_en", 32'(Sys_WrEn), 32'd1);
            checkVal("wr_data", Sys_WrData, monE.data);
            checkVal("rd_hold", Resp_RdData, lastRd);
          end else begin
            checkVal("rd_data", Resp_RdData, monE.data);
            checkVal("rd_en_resp", 32'(Sys_RdEn), 32'd0);
            lastRd = monE.data;
          end
        end
      end
    end
  end

  // Called just after a falling edge; returns #1 after the falling edge following accept.
  task automatic doReq(input bit w, input logic [29:0] a, input logic [31:0] d);
    bit got;
    expT e;
    got         = 1'b0;
    Req_Valid   = 1'b1;
    Req_Write   = w;
    Req_Address = a;
    Req_WrData  = d;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (Req_Ready) begin
        e.isWrite = w;
        e.addr    = a;
        e.data    = w ? d : periphData(a);
        e.dueCyc  = cyc + (w ? 1 : int'(RdLat) + 2);
        expQ.push_back(e);
        got = 1'b1;
      end
      @(negedge Sys_Clock);
    end
    Req_Valid = 1'b0;
    #1;
    if (!got) checkVal("accept_timeout", 32'(got), 32'd1);
    else checkVal("busy_after_accept", 32'(Req_Ready), 32'd0);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && expQ.size() != 0; i++) @(negedge Sys_Clock);
    if (expQ.size() != 0) checkVal("drain_timeout", 32'(expQ.size()), 32'd0);
    @(negedge Sys_Clock);
  endtask

  initial begin
    expT e;
    Sys_Reset = 1'b1; Req_Valid = 1'b0; Req_Write = 1'b0; Req_Address = '0; Req_WrData = '0;
    EIC_IntReq = 1'b0; EIC_IntId = 1'b0; Int_Enable = 1'b0; Int_Take = 1'b0;
    repeat (2) @(negedge Sys_Clock);
    #1;
    checkVal("rst_ready", 32'(Req_Ready), 32'd1);
    checkVal("rst_resp", 32'(Resp_Valid), 32'd0);
    checkVal("rst_wren", 32'(Sys_WrEn), 32'd0);
    checkVal("rst_rden", 32'(Sys_RdEn), 32'd0);
    checkVal("rst_addr", 32'(Sys_Address), 32'd0);
    checkVal("rst_wdata", Sys_WrData, 32'd0);
    checkVal("rst_rdata", Resp_RdData, 32'd0);
    checkVal("rst_pend", 32'(Int_Pending), 32'd0);
    checkVal("rst_intid", 32'(Int_Id), 32'd0);
    checkVal("rst_ack", 32'(EIC_IntAck), 32'd0);
    Sys_Reset = 1'b0;
    @(negedge Sys_Clock);

    doReq(1'b1, 30'h4, 32'hA5A5_0001);
    @(negedge Sys_Clock); #1;
    checkVal("ready_after_wr", 32'(Req_Ready), 32'd1);
    waitDrain();

    rdEnCount = 0;
    doReq(1'b0, 30'h0, 32'h0);
    waitDrain();
    checkVal("rd_val_fixed", Resp_RdData, 32'h1234_5678);
    checkVal("rden_pulses", 32'(rdEnCount), 32'd1);

    // Back-to-back mixed traffic: each request waits only for Req_Ready.
    for (int i = 0; i < 8; i++) begin
      doReq(1'($urandom_range(0, 1)), 30'($urandom()), $urandom());
    end
    waitDrain();

    // Interrupt wins against a simultaneous request.
    Req_Valid = 1'b1; Req_Write = 1'b1; Req_Address = 30'h3C; Req_WrData = 32'hCAFE_0003;
    EIC_IntReq = 1'b1; EIC_IntId = 1'b1; Int_Enable = 1'b1;
    #1 checkVal("int_blocks_ready", 32'(Req_Ready), 32'd0);
    @(negedge Sys_Clock); #1;
    checkVal("int_pend", 32'(Int_Pending), 32'd1);
    checkVal("int_id1", 32'(Int_Id), 32'd1);
    checkVal("int_ready", 32'(Req_Ready), 32'd0);
    checkVal("int_ack_early", 32'(EIC_IntAck), 32'd0);
    Int_Take = 1'b1;
    @(negedge Sys_Clock);
    Int_Take = 1'b0;
    #1;
    checkVal("ack_pulse", 32'(EIC_IntAck), 32'd1);
    checkVal("pend_clear", 32'(Int_Pending), 32'd0);
    checkVal("ready_after_take", 32'(Req_Ready), 32'd1);
    e.isWrite = 1'b1; e.addr = 30'h3C; e.data = 32'hCAFE_0003; e.dueCyc = cyc + 1;
    expQ.push_back(e);
    @(negedge Sys_Clock);
    Req_Valid = 1'b0;
    #1 checkVal("ack_one_cycle", 32'(EIC_IntAck), 32'd0);
    repeat (4) @(negedge Sys_Clock);
    #1 checkVal("no_repend_held", 32'(Int_Pending), 32'd0);
    EIC_IntReq = 1'b0;
    @(negedge Sys_Clock);
    EIC_IntReq = 1'b1; EIC_IntId = 1'b0;
    @(negedge Sys_Clock); #1;
    checkVal("repend_new_level", 32'(Int_Pending), 32'd1);
    checkVal("int_id0", 32'(Int_Id), 32'd0);
    Int_Enable = 1'b0;
    @(negedge Sys_Clock); #1;
    checkVal("pend_sticky", 32'(Int_Pending), 32'd1);
    Int_Take = 1'b1; EIC_IntReq = 1'b0;
    @(negedge Sys_Clock);
    Int_Take = 1'b0;
    #1 checkVal("ack_pulse2", 32'(EIC_IntAck), 32'd1);
    @(negedge Sys_Clock);
    #1 checkVal("ack_one_cycle2", 32'(EIC_IntAck), 32'd0);
    waitDrain();

    // Reset while waiting on read data aborts the access.
    doReq(1'b0, 30'h22, 32'h0);
    @(negedge Sys_Clock);
    Sys_Reset = 1'b1;
    expQ.delete();
    lastRd = 32'd0;
    #1;
    checkVal("abort_rden", 32'(Sys_RdEn), 32'd0);
    checkVal("abort_resp", 32'(Resp_Valid), 32'd0);
    checkVal("abort_addr", 32'(Sys_Address), 32'd0);
    checkVal("abort_rdata", Resp_RdData, 32'd0);
    checkVal("abort_wdata", Sys_WrData, 32'd0);
    @(negedge Sys_Clock);
    Sys_Reset = 1'b0;
    rdEnCount = 0;
    #1 checkVal("ready_after_rst", 32'(Req_Ready), 32'd1);
    repeat (8) @(negedge Sys_Clock);
    #1 checkVal("no_rden_after_rst", 32'(rdEnCount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
